paddle_bank: RTL

Multi-channel paddle position controller for the pong datapath. It holds the vertical position of `N_PADDLES` independent paddles, driven by per-player two-bit button inputs. Positions update once per frame tick and saturate at the playfield boundaries, so a paddle can always move away from an edge. The block sits between the button synchroniser/debouncer and the renderer and collision logic in the top module, and replaces the one-instance-per-paddle arrangement.

---
 rtl/paddle_bank.sv | 90 +++++++++
 1 files changed

// File: rtl/paddle_bank.sv
// paddle_bank: per-channel paddle y position with boundary saturation, updated on frame_tick.
// Define PADDLE_ACCEL_EN to enable step acceleration while a direction is held.
module paddle_bank #(
    parameter int N_PADDLES       = 2,
    parameter int YW              = 10,
    parameter int TOP_BOUNDARY    = 0,
    parameter int BOTTOM_BOUNDARY = 400,
    parameter int INIT_Y          = 240,
    parameter int DY              = 4,
    parameter int DY_MAX          = 12,
    parameter int ACCEL_HOLD      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic [2*N_PADDLES-1:0] btn,
    input  logic [N_PADDLES-1:0]   recenter,
    output logic [YW*N_PADDLES-1:0] y_pos,
    output logic [N_PADDLES-1:0]   at_top,
    output logic [N_PADDLES-1:0]   at_bottom
);
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;
    localparam logic [YW-1:0] TOP_Y  = YW'(TOP_BOUNDARY);
    localparam logic [YW-1:0] BOT_Y  = YW'(BOTTOM_BOUNDARY);
    localparam logic [YW-1:0] INIT_V = YW'(INIT_Y);
    localparam logic [YW:0]   TOP_W  = (YW+1)'(TOP_BOUNDARY);
    localparam logic [YW:0]   BOT_W  = (YW+1)'(BOTTOM_BOUNDARY);
    localparam logic [YW:0]   STEP0  = (YW+1)'(DY);
`ifdef PADDLE_ACCEL_EN
    localparam logic [YW:0]   STEP_MAX = (YW+1)'(DY_MAX);
    localparam int            HW       = $clog2(ACCEL_HOLD + 1);
`endif
    genvar i;
    for (i = 0; i < N_PADDLES; i++) begin : g_ch
        state_t state_q, state_d, dir;
        logic [YW-1:0] y_q, y_d;
        logic [YW:0] y_w, sum, step_cur;
        always_comb dir = btn[2*i +: 2] == 2'b01 ? DOWN : btn[2*i +: 2] == 2'b10 ? UP : IDLE;
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                y_q     <= INIT_V;
            end else begin
                state_q <= state_d;
                y_q     <= y_d;
            end
        end
        always_comb state_d = recenter[i] ? IDLE : frame_tick ? dir : state_q;
        // sum is one bit wider than y so a move near the bottom cannot wrap
        always_comb begin
            y_w = {1'b0, y_q};
            sum = y_w + step_cur;
            y_d = recenter[i] ? INIT_V :
                  !frame_tick ? y_q :
                  dir == DOWN ? (sum > BOT_W ? BOT_Y : sum[YW-1:0]) :
                  dir == UP   ? (y_w < TOP_W + step_cur ? TOP_Y : y_q - step_cur[YW-1:0]) :
                  y_q;
        end
`ifdef PADDLE_ACCEL_EN
        logic [YW:0] step_q, step_d, step_up;
        logic [HW-1:0] hold_q, hold_d, hold_inc;
        logic fresh;
        always_ff @(posedge clk) begin
            if (rst) begin
                step_q <= STEP0;
                hold_q <= '0;
            end else begin
                step_q <= step_d;
                hold_q <= hold_d;
            end
        end
        // idle or a change of direction restarts from the base step before moving
        always_comb begin
            fresh    = dir == IDLE || dir != state_q;
            step_cur = fresh ? STEP0 : step_q;
            hold_inc = (fresh ? '0 : hold_q) + 1'b1;
            step_up  = step_cur + STEP0 > STEP_MAX ? STEP_MAX : step_cur + STEP0;
            step_d   = recenter[i] ? STEP0 : !frame_tick ? step_q : dir == IDLE ? STEP0 :
                       hold_inc == HW'(ACCEL_HOLD) ? step_up : step_cur;
            hold_d   = recenter[i] ? '0 : !frame_tick ? hold_q : dir == IDLE ? '0 :
                       hold_inc == HW'(ACCEL_HOLD) ? '0 : hold_inc;
        end
`else
        assign step_cur = STEP0;
`endif
        assign y_pos[YW*i +: YW] = y_q;
        assign at_top[i]         = y_q == TOP_Y;
        assign at_bottom[i]      = y_q == BOT_Y;
    end
endmodule
